ibex_ahbl_arbiter: RTL and testbench

- Shares one AHB-Lite master port between the Ibex instruction and data request/grant/rvalid interfaces.
- Issues a new address phase in the same cycle as the previous data phase, giving full AHB pipelining (one transfer per cycle at zero wait states).
- Converts byte enables to HSIZE plus a low address offset.
- Routes HRDATA, rvalid and error back to the interface that owns the transfer.

---
 rtl/ibex_ahbl_pkg.sv | 18 +
 rtl/ibex_be2hsize.sv | 28 ++
 rtl/ibex_ahbl_arbiter.sv | 128 ++++++++++++
 tb/tb_ibex_ahbl_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_ahbl_pkg.sv
// rtl/ibex_ahbl_pkg.sv - shared AHB-Lite encodings and data-phase states for the Ibex arbiter
package ibex_ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        DP_IDLE  = 2'd0,
        DP_INSTR = 2'd1,
        DP_DATA  = 2'd2,
        DP_ERR2  = 2'd3
    } dp_state_e;

endpackage

// File: rtl/ibex_be2hsize.sv
// rtl/ibex_be2hsize.sv - maps Ibex byte enables to AHB HSIZE plus low address offset
module ibex_be2hsize
    import ibex_ahbl_pkg::*;
(
    input  logic [3:0] be_i,
    output logic [2:0] hsize_o,
    output logic [1:0] offset_o,
    output logic       align_o
);

    // align_o marks non-contiguous patterns: issued as a word with HADDR[1:0] cleared
    always_comb begin
        hsize_o  = HSIZE_WORD;
        offset_o = 2'b00;
        align_o  = 1'b1;
        case (be_i)
            4'b0001: begin hsize_o = HSIZE_BYTE; offset_o = 2'd0; align_o = 1'b0; end
            4'b0010: begin hsize_o = HSIZE_BYTE; offset_o = 2'd1; align_o = 1'b0; end
            4'b0100: begin hsize_o = HSIZE_BYTE; offset_o = 2'd2; align_o = 1'b0; end
            4'b1000: begin hsize_o = HSIZE_BYTE; offset_o = 2'd3; align_o = 1'b0; end
            4'b0011: begin hsize_o = HSIZE_HALF; offset_o = 2'd0; align_o = 1'b0; end
            4'b1100: begin hsize_o = HSIZE_HALF; offset_o = 2'd2; align_o = 1'b0; end
            4'b1111: begin hsize_o = HSIZE_WORD; offset_o = 2'd0; align_o = 1'b0; end
            default: begin hsize_o = HSIZE_WORD; offset_o = 2'd0; align_o = 1'b1; end
        endcase
    end

endmodule

// File: rtl/ibex_ahbl_arbiter.sv
// rtl/ibex_ahbl_arbiter.sv - shares one pipelined AHB-Lite master between Ibex instr and data ports
module ibex_ahbl_arbiter
    import ibex_ahbl_pkg::*;
#(
    parameter bit DATA_PRIORITY = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic [31:0] HADDR,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    dp_state_e   dp_state_q, dp_state_d;
    logic [31:0] dp_wdata_q, dp_wdata_d;
    logic        rr_last_q, rr_last_d;
    logic        err_data_q, err_data_d;

    logic [2:0]  be_hsize;
    logic [1:0]  be_offset;
    logic        be_align;
    logic        addr_ok, tie, tie_data, gnt_instr, gnt_data, dp_active;

    ibex_be2hsize u_be2hsize (
        .be_i     (data_be_i),
        .hsize_o  (be_hsize),
        .offset_o (be_offset),
        .align_o  (be_align)
    );

    // Address phase gated by HRESETn so no grant leaks out while reset is held
    always_comb begin
        addr_ok   = HRESETn && HREADY && (dp_state_q != DP_ERR2);
        tie       = instr_req_i && data_req_i;
        tie_data  = DATA_PRIORITY ? 1'b1 : ~rr_last_q;
        gnt_data  = addr_ok && data_req_i && (!instr_req_i || tie_data);
        gnt_instr = addr_ok && instr_req_i && !(data_req_i && tie_data);

        HTRANS = HTRANS_IDLE;
        HADDR  = 32'h0;
        HSIZE  = 3'b000;
        HWRITE = 1'b0;
        if (gnt_data) begin
            HTRANS = HTRANS_NONSEQ;
            HADDR  = {data_addr_i[31:2], be_align ? 2'b00 : (data_addr_i[1:0] | be_offset)};
            HSIZE  = be_hsize;
            HWRITE = data_we_i;
        end else if (gnt_instr) begin
            HTRANS = HTRANS_NONSEQ;
            HADDR  = instr_addr_i;
            HSIZE  = HSIZE_WORD;
        end
    end

    assign instr_gnt_o   = gnt_instr;
    assign data_gnt_o    = gnt_data;
    assign HWDATA        = dp_wdata_q;
    assign instr_rdata_o = HRDATA;
    assign data_rdata_o  = HRDATA;

    always_comb begin
        dp_active      = (dp_state_q == DP_INSTR) || (dp_state_q == DP_DATA);
        instr_rvalid_o = HREADY && ((dp_state_q == DP_INSTR) ||
                                    ((dp_state_q == DP_ERR2) && !err_data_q));
        data_rvalid_o  = HREADY && ((dp_state_q == DP_DATA) ||
                                    ((dp_state_q == DP_ERR2) && err_data_q));
        instr_err_o    = instr_rvalid_o && ((dp_state_q == DP_ERR2) || HRESP);
        data_err_o     = data_rvalid_o && ((dp_state_q == DP_ERR2) || HRESP);
    end

    always_comb begin
        dp_state_d = dp_state_q;
        dp_wdata_d = dp_wdata_q;
        rr_last_d  = rr_last_q;
        err_data_d = err_data_q;
        if (dp_active && !HREADY && HRESP) begin
            dp_state_d = DP_ERR2;
            err_data_d = (dp_state_q == DP_DATA);
        end else if (HREADY) begin
            if (gnt_data) begin
                dp_state_d = DP_DATA;
                dp_wdata_d = data_wdata_i;
            end else if (gnt_instr) begin
                dp_state_d = DP_INSTR;
            end else begin
                dp_state_d = DP_IDLE;
            end
            if (tie && (gnt_data || gnt_instr)) begin
                rr_last_d = gnt_data;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_state_q <= DP_IDLE;
            dp_wdata_q <= 32'h0;
            rr_last_q  <= 1'b0;
            err_data_q <= 1'b0;
        end else begin
            dp_state_q <= dp_state_d;
            dp_wdata_q <= dp_wdata_d;
            rr_last_q  <= rr_last_d;
            err_data_q <= err_data_d;
        end
    end

endmodule

// File: tb/tb_ibex_ahbl_arbiter.sv
// tb/tb_ibex_ahbl_arbiter.sv - self-checking bench for ibex_ahbl_arbiter (priority and round-robin builds)
module tb_ibex_ahbl_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        instr_req, data_req, data_we, hready, hresp;
    logic [31:0] instr_addr, data_addr, data_wdata, hrdata;
    logic [3:0]  data_be;

    logic        instr_gnt [2], instr_rvalid [2], instr_err [2];
    logic        data_gnt [2], data_rvalid [2], data_err [2], hwrite [2];
    logic [31:0] instr_rdata [2], data_rdata [2], haddr [2], hwdata [2];
    logic [2:0]  hsize [2];
    logic [1:0]  htrans [2];

    // Reference model: at most one outstanding transfer per build, tracked by owner
    bit          m_pend [2], m_pend_data [2], m_err2 [2], m_rr_data [2], m_gd [2], m_gi [2];
    logic [31:0] m_wdata [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 HCLK = ~HCLK;

    ibex_ahbl_arbiter #(.DATA_PRIORITY(1'b1)) u_dut_prio (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt[0]),
        .instr_rvalid_o(instr_rvalid[0]), .instr_rdata_o(instr_rdata[0]), .instr_err_o(instr_err[0]),
        .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_gnt_o(data_gnt[0]), .data_rvalid_o(data_rvalid[0]),
        .data_rdata_o(data_rdata[0]), .data_err_o(data_err[0]),
        .HADDR(haddr[0]), .HSIZE(hsize[0]), .HTRANS(htrans[0]), .HWRITE(hwrite[0]),
        .HWDATA(hwdata[0]), .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp)
    );

    ibex_ahbl_arbiter #(.DATA_PRIORITY(1'b0)) u_dut_rr (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt[1]),
        .instr_rvalid_o(instr_rvalid[1]), .instr_rdata_o(instr_rdata[1]), .instr_err_o(instr_err[1]),
        .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_gnt_o(data_gnt[1]), .data_rvalid_o(data_rvalid[1]),
        .data_rdata_o(data_rdata[1]), .data_err_o(data_err[1]),
        .HADDR(haddr[1]), .HSIZE(hsize[1]), .HTRANS(htrans[1]), .HWRITE(hwrite[1]),
        .HWDATA(hwdata[1]), .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Size from the number of enabled lanes, offset from the lowest enabled lane
    function automatic void be_map(input logic [3:0] be, input logic [1:0] a,
                                   output logic [2:0] sz, output logic [1:0] lo);
        int n;
        int low;
        n   = $countones(be);
        low = 0;
        for (int i = 3; i >= 0; i--) if (be[i]) low = i;
        if (n == 1) begin
            sz = 3'b000; lo = a | low[1:0];
        end else if (n == 2 && (be == 4'b0011 || be == 4'b1100)) begin
            sz = 3'b001; lo = a | low[1:0];
        end else if (n == 4) begin
            sz = 3'b010; lo = a;
        end else begin
            sz = 3'b010; lo = 2'b00;
        end
    endfunction

    task automatic settle();
        #1;
        for (int k = 0; k < 2; k++) begin
            logic        ok, win_d, gd, gi, resp, eerr;
            logic [2:0]  sz;
            logic [1:0]  lo;
            logic [31:0] ea, ewd;
            string       p;
            p = (k == 0) ? "prio" : "rr";
            gd = 1'b0; gi = 1'b0; resp = 1'b0; ea = 32'h0; sz = 3'b000; lo = 2'b00;
            if (HRESETn) begin
                ok    = hready && !m_err2[k];
                win_d = (k == 0) ? 1'b1 : !m_rr_data[k];
                gd    = ok && data_req && (!instr_req || win_d);
                gi    = ok && instr_req && !(data_req && win_d);
                resp  = hready && m_pend[k];
                if (gd) begin
                    be_map(data_be, data_addr[1:0], sz, lo);
                    ea = {data_addr[31:2], lo};
                end else if (gi) begin
                    ea = instr_addr;
                    sz = 3'b010;
                end
            end
            ewd  = HRESETn ? m_wdata[k] : 32'h0;
            eerr = m_err2[k] || hresp;
            m_gd[k] = gd;
            m_gi[k] = gi;
            chk({p, " instr_gnt"}, instr_gnt[k], gi);
            chk({p, " data_gnt"}, data_gnt[k], gd);
            chk({p, " htrans"}, htrans[k], (gd || gi) ? 2'b10 : 2'b00);
            chk({p, " haddr"}, haddr[k], ea);
            chk({p, " hsize"}, hsize[k], sz);
            chk({p, " hwrite"}, hwrite[k], gd && data_we);
            chk({p, " hwdata"}, hwdata[k], ewd);
            chk({p, " instr_rvalid"}, instr_rvalid[k], resp && !m_pend_data[k]);
            chk({p, " data_rvalid"}, data_rvalid[k], resp && m_pend_data[k]);
            chk({p, " instr_err"}, instr_err[k], resp && !m_pend_data[k] && eerr);
            chk({p, " data_err"}, data_err[k], resp && m_pend_data[k] && eerr);
            chk({p, " instr_rdata"}, instr_rdata[k], hrdata);
            chk({p, " data_rdata"}, data_rdata[k], hrdata);
        end
    endtask

    task automatic advance();
        @(posedge HCLK);
        for (int k = 0; k < 2; k++) begin
            if (!HRESETn) begin
                m_pend[k] = 0; m_pend_data[k] = 0; m_err2[k] = 0; m_rr_data[k] = 0;
                m_wdata[k] = 32'h0;
            end else if (m_pend[k] && !m_err2[k] && !hready && hresp) begin
                m_err2[k] = 1;
            end else if (hready) begin
                if (instr_req && data_req && (m_gd[k] || m_gi[k])) m_rr_data[k] = m_gd[k];
                m_err2[k]      = 0;
                m_pend[k]      = m_gd[k] || m_gi[k];
                m_pend_data[k] = m_gd[k];
                if (m_gd[k]) m_wdata[k] = data_wdata;
            end
        end
        @(negedge HCLK);
    endtask

    task automatic idle_inputs();
        instr_req = 0; instr_addr = 0; data_req = 0; data_we = 0; data_be = 4'b1111;
        data_addr = 0; data_wdata = 0; hrdata = 0; hready = 1; hresp = 0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = 0; m_pend_data[k] = 0; m_err2[k] = 0; m_rr_data[k] = 0;
            m_gd[k] = 0; m_gi[k] = 0; m_wdata[k] = 0;
        end
        HRESETn = 1'b0;
        idle_inputs();
        instr_req = 1; data_req = 1;
        @(negedge HCLK);
        settle();
        chk("reset htrans", htrans[0], 2'b00);
        chk("reset gnt", {instr_gnt[0], data_gnt[0], instr_gnt[1], data_gnt[1]}, 4'b0000);
        advance();
        settle();
        advance();

        // Round-robin on continuous ties starts with data
        HRESETn = 1'b1;
        data_we = 0; data_addr = 32'h1000; instr_addr = 32'h80;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("rr data_gnt", data_gnt[1], (i % 2 == 0) ? 1'b1 : 1'b0);
            chk("rr instr_gnt", instr_gnt[1], (i % 2 == 1) ? 1'b1 : 1'b0);
            chk("prio data_gnt", data_gnt[0], 1'b1);
            advance();
        end
        idle_inputs();
        settle();
        advance();

        // Instruction-only fetch
        instr_req = 1; instr_addr = 32'h100; hrdata = 32'h00000013;
        settle();
        chk("ifetch gnt", instr_gnt[0], 1'b1);
        chk("ifetch htrans", htrans[0], 2'b10);
        chk("ifetch hsize", hsize[0], 3'b010);
        advance();
        instr_req = 0;
        settle();
        chk("ifetch rvalid", instr_rvalid[0], 1'b1);
        chk("ifetch rdata", instr_rdata[0], 32'h00000013);
        advance();

        // Simultaneous requests with data priority
        instr_req = 1; instr_addr = 32'h200;
        data_req = 1; data_we = 1; data_be = 4'b1100; data_addr = 32'h2002; data_wdata = 32'hABCD0000;
        settle();
        chk("tie data_gnt", data_gnt[0], 1'b1);
        chk("tie haddr", haddr[0], 32'h2002);
        chk("tie hsize", hsize[0], 3'b001);
        chk("tie hwrite", hwrite[0], 1'b1);
        advance();
        data_req = 0;
        settle();
        chk("tie hwdata", hwdata[0], 32'hABCD0000);
        chk("tie instr_gnt", instr_gnt[0], 1'b1);
        advance();
        idle_inputs();
        settle();
        advance();

        // Wait states during a data write
        data_req = 1; data_we = 1; data_be = 4'b1111; data_addr = 32'h3000; data_wdata = 32'h5A5A1234;
        settle();
        advance();
        instr_req = 1; instr_addr = 32'h300; data_wdata = 32'h0; hready = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("wait hwdata", hwdata[0], 32'h5A5A1234);
            chk("wait gnt", {instr_gnt[0], data_gnt[0]}, 2'b00);
            chk("wait rvalid", data_rvalid[0], 1'b0);
            advance();
        end
        hready = 1;
        settle();
        chk("wait release rvalid", data_rvalid[0], 1'b1);
        chk("wait release hwdata", hwdata[0], 32'h5A5A1234);
        advance();
        idle_inputs();
        settle();
        advance();

        // Two-cycle error response on an instruction fetch
        instr_req = 1; instr_addr = 32'h400;
        settle();
        advance();
        hready = 0; hresp = 1;
        settle();
        chk("err1 htrans", htrans[0], 2'b00);
        chk("err1 rvalid", instr_rvalid[0], 1'b0);
        advance();
        hready = 1; hresp = 1;
        settle();
        chk("err2 htrans", htrans[0], 2'b00);
        chk("err2 rvalid", instr_rvalid[0], 1'b1);
        chk("err2 err", instr_err[0], 1'b1);
        chk("err2 gnt", instr_gnt[0], 1'b0);
        advance();
        hresp = 0;
        settle();
        chk("err after gnt", instr_gnt[0], 1'b1);
        advance();
        idle_inputs();
        settle();
        advance();

        // Reset during a stalled data phase
        data_req = 1; data_we = 1; data_addr = 32'h500; data_wdata = 32'h77;
        settle();
        advance();
        hready = 0;
        settle();
        advance();
        HRESETn = 1'b0;
        settle();
        chk("rst htrans", htrans[0], 2'b00);
        chk("rst hwdata", hwdata[0], 32'h0);
        chk("rst gnt", data_gnt[0], 1'b0);
        chk("rst rvalid", data_rvalid[0], 1'b0);
        advance();
        HRESETn = 1'b1; hready = 1; data_req = 0;
        settle();
        chk("rst release rvalid", data_rvalid[0], 1'b0);
        advance();
        settle();
        advance();

        // Randomised traffic against the model
        for (int i = 0; i < 500; i++) begin
            instr_req  = ($urandom_range(0, 2) != 0);
            data_req   = ($urandom_range(0, 2) != 0);
            data_we    = $urandom_range(0, 1);
            data_be    = 4'($urandom_range(0, 15));
            instr_addr = $urandom;
            data_addr  = $urandom;
            data_wdata = $urandom;
            hrdata     = $urandom;
            hready     = ($urandom_range(0, 3) != 0);
            hresp      = ($urandom_range(0, 5) == 0);
            HRESETn    = ($urandom_range(0, 99) != 0);
            settle();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
